// File: rtl/dotprod_ctrl.sv
// dotprod_ctrl: collects eight (a,b) element pairs from a valid/ready stream,
// hands them to the dotprod engine with a one-cycle start pulse, waits for
// done under a timeout, and returns the result on a valid/ready stream.
// Optional build macro DOTPROD_CTRL_ACCUM_EN adds a running accumulator over
// successive results, cleared by the acc_clr input.
module dotprod_ctrl #(
  parameter int unsigned DW      = 32,
  parameter int unsigned RW      = 64,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_a,
  input  logic [DW-1:0]     in_b,
  output logic [8*DW-1:0]   dp_a,
  output logic [8*DW-1:0]   dp_b,
  output logic              dp_start,
  input  logic              dp_done,
  input  logic [RW-1:0]     dp_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RW-1:0]     res_data,
  output logic              res_err,
  output logic              busy
`ifdef DOTPROD_CTRL_ACCUM_EN
  ,
  input  logic              acc_clr
`endif
);

  localparam int unsigned     CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_LOAD, S_START, S_WAIT, S_OUT} state_t;

  state_t            r_state;
  logic [2:0]        r_elem_cnt;
  logic [CW-1:0]     r_to_cnt;
  logic [8*DW-1:0]   r_dp_a;
  logic [8*DW-1:0]   r_dp_b;
  logic              r_dp_start;
  logic              r_in_ready;
  logic              r_busy;
  logic              r_res_valid;
  logic [RW-1:0]     r_res_data;
  logic              r_res_err;
  logic [RW-1:0]     w_done_val;

`ifdef DOTPROD_CTRL_ACCUM_EN
  logic [RW-1:0]     r_acc;
  logic [RW-1:0]     w_acc_base;

  // A clear coinciding with done is applied before the add.
  assign w_acc_base = acc_clr ? '0 : r_acc;
  assign w_done_val = w_acc_base + dp_result;

  // Running accumulator: loads the new total on done, zeroes on acc_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (r_state == S_WAIT && dp_done) begin
      r_acc <= w_done_val;
    end else if (acc_clr) begin
      r_acc <= '0;
    end
  end
`else
  assign w_done_val = dp_result;
`endif

  // Job sequencer: load operands, pulse start, wait for done/timeout, return result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_LOAD;
      r_elem_cnt  <= '0;
      r_to_cnt    <= '0;
      r_dp_a      <= '0;
      r_dp_b      <= '0;
      r_dp_start  <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_err   <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (in_valid && r_in_ready) begin
            r_dp_a[int'(r_elem_cnt)*DW +: DW] <= in_a;
            r_dp_b[int'(r_elem_cnt)*DW +: DW] <= in_b;
            r_elem_cnt <= r_elem_cnt + 3'd1;
            if (r_elem_cnt == 3'd7) begin
              r_state    <= S_START;
              r_dp_start <= 1'b1;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
            end
          end
        end
        S_START: begin
          r_dp_start <= 1'b0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          r_to_cnt <= r_to_cnt + CW'(1);
          if (dp_done) begin
            r_res_data  <= w_done_val;
            r_res_err   <= 1'b0;
            r_res_valid <= 1'b1;
            r_state     <= S_OUT;
          end else if (r_to_cnt == TO_LAST) begin
            r_res_data  <= '0;
            r_res_err   <= 1'b1;
            r_res_valid <= 1'b1;
            r_state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_to_cnt    <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_LOAD;
          end
        end
        default: begin
          r_state <= S_LOAD;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign dp_a      = r_dp_a;
  assign dp_b      = r_dp_b;
  assign dp_start  = r_dp_start;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_err   = r_res_err;

endmodule

// File: tb/tb_dotprod_ctrl.sv
// Testbench for dotprod_ctrl: plays the stream source, the dotprod engine and
// the result consumer; expected results come from a plain dot-product model.
module tb_dotprod_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 64;
  localparam int unsigned TO = 200;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_a = '0;
  logic [DW-1:0]   in_b = '0;
  logic [8*DW-1:0] dp_a;
  logic [8*DW-1:0] dp_b;
  logic            dp_start;
  logic            dp_done = 1'b0;
  logic [RW-1:0]   dp_result = '0;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic [RW-1:0]   res_data;
  logic            res_err;
  logic            busy;
`ifdef DOTPROD_CTRL_ACCUM_EN
  logic            acc_clr = 1'b0;
`endif

  dotprod_ctrl #(.DW(DW), .RW(RW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .dp_a      (dp_a),
    .dp_b      (dp_b),
    .dp_start  (dp_start),
    .dp_done   (dp_done),
    .dp_result (dp_result),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err),
    .busy      (busy)
`ifdef DOTPROD_CTRL_ACCUM_EN
    ,
    .acc_clr   (acc_clr)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned start_cnt = 0;

  logic [DW-1:0] va [8];
  logic [DW-1:0] vb [8];
  logic [RW-1:0] m_acc = '0;

  always @(negedge clk) if (dp_start) start_cnt++;

  task automatic chk(input string tag, input logic [8*DW-1:0] obs, input logic [8*DW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [RW-1:0] model_dot();
    logic [RW-1:0] s = '0;
    for (int i = 0; i < 8; i++) s += RW'(va[i]) * RW'(vb[i]);
    return s;
  endfunction

  function automatic logic [8*DW-1:0] pack_a();
    logic [8*DW-1:0] v = '0;
    for (int i = 0; i < 8; i++) v[i*DW +: DW] = va[i];
    return v;
  endfunction

  function automatic logic [8*DW-1:0] pack_b();
    logic [8*DW-1:0] v = '0;
    for (int i = 0; i < 8; i++) v[i*DW +: DW] = vb[i];
    return v;
  endfunction

  // Engine stand-in: computes its answer from the operand buses it is given.
  function automatic logic [RW-1:0] engine_result();
    logic [RW-1:0] s = '0;
    for (int i = 0; i < 8; i++) s += RW'(dp_a[i*DW +: DW]) * RW'(dp_b[i*DW +: DW]);
    return s;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_vec(input int unsigned a0, a1, a2, a3, a4, a5, a6, a7,
                         input int unsigned b0, b1, b2, b3, b4, b5, b6, b7);
    va[0] = a0; va[1] = a1; va[2] = a2; va[3] = a3;
    va[4] = a4; va[5] = a5; va[6] = a6; va[7] = a7;
    vb[0] = b0; vb[1] = b1; vb[2] = b2; vb[3] = b3;
    vb[4] = b4; vb[5] = b5; vb[6] = b6; vb[7] = b7;
  endtask

  task automatic set_random();
    for (int i = 0; i < 8; i++) begin
      va[i] = $urandom;
      vb[i] = $urandom;
    end
  endtask

  task automatic stream();
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      chk("in_ready_load", in_ready, 1);
      in_valid = 1'b1;
      in_a = va[i];
      in_b = vb[i];
      tick();
      in_valid = 1'b0;
      in_a = $urandom;
      in_b = $urandom;
    end
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("res_valid_drop", res_valid, 0);
    chk("in_ready_after", in_ready, 1);
    chk("busy_after", busy, 0);
  endtask

  task automatic run_job(input int dly, input int hold, input bit clr_with_done);
    int unsigned s0 = start_cnt;
    logic [RW-1:0] exp;
    stream();
    chk("dp_start_pulse", dp_start, 1);
    chk("in_ready_start", in_ready, 0);
    chk("busy_start", busy, 1);
    chk("dp_a_pack", dp_a, pack_a());
    chk("dp_b_pack", dp_b, pack_b());
    tick();
    chk("dp_start_one", dp_start, 0);
    repeat (dly) tick();
    chk("res_valid_wait", res_valid, 0);
    dp_result = engine_result();
    dp_done = 1'b1;
`ifdef DOTPROD_CTRL_ACCUM_EN
    acc_clr = clr_with_done;
`endif
    tick();
    dp_done = 1'b0;
    dp_result = {$urandom, $urandom};
`ifdef DOTPROD_CTRL_ACCUM_EN
    acc_clr = 1'b0;
    m_acc = (clr_with_done ? '0 : m_acc) + model_dot();
    exp = m_acc;
`else
    exp = model_dot();
`endif
    chk("res_valid", res_valid, 1);
    chk("res_data", res_data, exp);
    chk("res_err", res_err, 0);
    chk("in_ready_out", in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("res_valid_hold", res_valid, 1);
      chk("res_data_hold", res_data, exp);
      chk("in_ready_hold", in_ready, 0);
    end
    chk("dp_a_stable", dp_a, pack_a());
    chk("dp_b_stable", dp_b, pack_b());
    handshake();
    chk("start_count", start_cnt - s0, 1);
  endtask

  task automatic run_timeout();
    int n = 0;
    stream();
    chk("dp_start_pulse_to", dp_start, 1);
    tick();
    while (!res_valid && n < 2 * TO) begin
      tick();
      n++;
    end
    chk("timeout_cycles", n, TO);
    chk("timeout_err", res_err, 1);
    chk("timeout_data", res_data, 0);
    dp_result = {$urandom, $urandom};
    dp_done = 1'b1;
    tick();
    dp_done = 1'b0;
    chk("late_done_valid", res_valid, 1);
    chk("late_done_err", res_err, 1);
    chk("late_done_data", res_data, 0);
    handshake();
    dp_done = 1'b1;
    tick();
    dp_done = 1'b0;
    chk("late_done_load", busy, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_dp_start", dp_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_err", res_err, 0);
    chk("rst_dp_a", dp_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1);

    // fixed vectors: 170, 120, 20
    set_vec(2, 7, 5, 3, 5, 6, 7, 8, 8, 7, 6, 5, 4, 3, 2, 1);
    run_job(3, 0, 0);
    set_vec(1, 2, 3, 4, 5, 6, 7, 8, 8, 7, 6, 5, 4, 3, 2, 1);
    run_job(0, 0, 0);
    set_vec(1, 2, 3, 4, 5, 6, 7, 8, 0, 1, 0, 1, 0, 1, 0, 1);
    run_job(1, 0, 0);

    // consumer backpressure for 5 cycles
    set_vec(2, 7, 5, 3, 5, 6, 7, 8, 8, 7, 6, 5, 4, 3, 2, 1);
    run_job(2, 5, 0);

    // done on the same cycle the timeout would fire
    set_random();
    run_job(TO - 1, 1, 0);

    // engine never answers
    run_timeout();

    // reset in the middle of WAIT
    set_vec(2, 7, 5, 3, 5, 6, 7, 8, 8, 7, 6, 5, 4, 3, 2, 1);
    stream();
    tick();
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    m_acc = '0;
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_dp_start", dp_start, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_res_err", res_err, 0);
    chk("mid_rst_res_data", res_data, 0);
    chk("mid_rst_dp_a", dp_a, 0);
    chk("mid_rst_dp_b", dp_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", in_ready, 1);
    repeat (3) tick();
    chk("post_rst_no_valid", res_valid, 0);
    chk("post_rst_no_start", dp_start, 0);
    run_job(4, 0, 0);

    // random jobs
    for (int j = 0; j < 15; j++) begin
      set_random();
      run_job($urandom_range(0, 20), $urandom_range(0, 4), 1'b0);
    end

`ifdef DOTPROD_CTRL_ACCUM_EN
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    m_acc = '0;
    set_vec(1, 2, 3, 4, 5, 6, 7, 8, 0, 1, 0, 1, 0, 1, 0, 1);
    run_job(2, 0, 0);
    set_random();
    run_job(3, 0, 1'b1);
    set_random();
    run_job(1, 0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
